// File: rtl/eit_scan_sequencer_if.sv
// eit_scan_sequencer_if: handshake bundle between the scan sequencer, its controller and the mux/DAC/ADC drivers
interface eit_scan_sequencer_if #(
    parameter int N_ELEC  = 16,
    parameter int SAMPLES = 4
);
    localparam int IDX_W = $clog2(N_ELEC);
    localparam int SMP_W = $clog2(SAMPLES + 1);
    logic             start, abort, continuous, step_done, dac_ready, adc_ready;
    logic             start_mux, start_dac, start_adc, meas_valid, fsm_busy, fsm_done, timeout_err;
    logic [IDX_W-1:0] inj_p, inj_n, meas_p, meas_n;
    logic [SMP_W-1:0] sample_idx;
    modport master (
        output start, abort, continuous, step_done, dac_ready, adc_ready,
        input  start_mux, start_dac, start_adc, meas_valid, fsm_busy, fsm_done, timeout_err,
        input  inj_p, inj_n, meas_p, meas_n, sample_idx
    );
    modport slave (
        input  start, abort, continuous, step_done, dac_ready, adc_ready,
        output start_mux, start_dac, start_adc, meas_valid, fsm_busy, fsm_done, timeout_err,
        output inj_p, inj_n, meas_p, meas_n, sample_idx
    );
endinterface

// File: rtl/eit_scan_sequencer.sv
// eit_scan_sequencer: walks a full adjacent-pattern EIT frame, sequencing mux, settle, DAC and ADC samples per measurement
module eit_scan_sequencer #(
    parameter int N_ELEC         = 16,
    parameter int SAMPLES        = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SKIP_INJ       = 1
) (
    input logic                 clk,
    input logic                 rst,
    eit_scan_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(N_ELEC);
    localparam int SMP_W = $clog2(SAMPLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 2);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEC - 1);

    typedef enum logic [2:0] {IDLE, MUX, SETTLE, DAC, ADC, NEXT, DONE, ERR} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] inj_p_q, meas_p_q;
    logic [SMP_W-1:0] smp_q;
    logic [SET_W-1:0] settle_q;
    logic [TMO_W-1:0] tmo_q;
    logic             start_mux_q, start_dac_q, start_adc_q, meas_valid_q, fsm_done_q, timeout_err_q;
    logic [IDX_W-1:0] meas_nxt_d, meas_first_d, meas_first_nxt_inj_d;
    logic             meas_more_d, tmo_hit_d;

    // explicit modulo-N increment so non-power-of-two electrode counts wrap correctly
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
        return (x == LAST) ? '0 : x + 1'b1;
    endfunction

    // a measurement pair is usable unless it shares an electrode with the injection pair
    function automatic logic pair_ok(input logic [IDX_W-1:0] ip, input logic [IDX_W-1:0] mp);
        return (SKIP_INJ == 0) || !(mp == ip || mp == wrap_inc(ip) || wrap_inc(mp) == ip);
    endfunction

    function automatic logic [IDX_W-1:0] first_ok(input logic [IDX_W-1:0] ip);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int m = N_ELEC - 1; m >= 0; m--)
            if (pair_ok(ip, IDX_W'(m))) r = IDX_W'(m);
        return r;
    endfunction

    // lowest usable measurement pair above the current one, plus the reload targets for a new injection
    always_comb begin
        meas_more_d = 1'b0;
        meas_nxt_d = '0;
        for (int m = N_ELEC - 1; m >= 0; m--)
            if (m > int'(meas_p_q) && pair_ok(inj_p_q, IDX_W'(m))) begin
                meas_more_d = 1'b1;
                meas_nxt_d = IDX_W'(m);
            end
        meas_first_d = first_ok('0);
        meas_first_nxt_inj_d = first_ok(wrap_inc(inj_p_q));
        tmo_hit_d = tmo_q == TMO_W'(TIMEOUT_CYCLES - 1);
    end

    // sequencer FSM; every output is registered and pulses fall back to zero each cycle
    always_ff @(posedge clk) begin
        start_mux_q <= 1'b0;
        start_dac_q <= 1'b0;
        start_adc_q <= 1'b0;
        meas_valid_q <= 1'b0;
        fsm_done_q <= 1'b0;
        if (rst || bus.abort) begin
            state_q <= IDLE;
            inj_p_q <= '0;
            meas_p_q <= '0;
            smp_q <= '0;
            settle_q <= '0;
            tmo_q <= '0;
            if (rst) timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= MUX;
                    start_mux_q <= 1'b1;
                    timeout_err_q <= 1'b0;
                    inj_p_q <= '0;
                    meas_p_q <= meas_first_d;
                    smp_q <= '0;
                    tmo_q <= '0;
                end
                MUX: if (bus.step_done) begin
                    state_q <= (SETTLE_CYCLES == 0) ? DAC : SETTLE;
                    start_dac_q <= (SETTLE_CYCLES == 0);
                    settle_q <= '0;
                    tmo_q <= '0;
                end else if (tmo_hit_d) begin
                    state_q <= ERR;
                    timeout_err_q <= 1'b1;
                end else tmo_q <= tmo_q + 1'b1;
                SETTLE: if (settle_q + 1'b1 == SET_W'(SETTLE_CYCLES)) begin
                    state_q <= DAC;
                    start_dac_q <= 1'b1;
                    tmo_q <= '0;
                end else settle_q <= settle_q + 1'b1;
                DAC: if (bus.dac_ready) begin
                    state_q <= ADC;
                    start_adc_q <= 1'b1;
                    tmo_q <= '0;
                end else if (tmo_hit_d) begin
                    state_q <= ERR;
                    timeout_err_q <= 1'b1;
                end else tmo_q <= tmo_q + 1'b1;
                ADC: if (bus.adc_ready) begin
                    smp_q <= smp_q + 1'b1;
                    tmo_q <= '0;
                    state_q <= (smp_q == SMP_W'(SAMPLES - 1)) ? NEXT : ADC;
                    meas_valid_q <= (smp_q == SMP_W'(SAMPLES - 1));
                    start_adc_q <= (smp_q != SMP_W'(SAMPLES - 1));
                end else if (tmo_hit_d) begin
                    state_q <= ERR;
                    timeout_err_q <= 1'b1;
                end else tmo_q <= tmo_q + 1'b1;
                NEXT: begin
                    smp_q <= '0;
                    tmo_q <= '0;
                    if (meas_more_d) begin
                        meas_p_q <= meas_nxt_d;
                        state_q <= MUX;
                        start_mux_q <= 1'b1;
                    end else begin
                        inj_p_q <= wrap_inc(inj_p_q);
                        meas_p_q <= meas_first_nxt_inj_d;
                        state_q <= (inj_p_q == LAST) ? DONE : MUX;
                        start_mux_q <= (inj_p_q != LAST);
                        fsm_done_q <= (inj_p_q == LAST);
                    end
                end
                DONE: begin
                    state_q <= bus.continuous ? MUX : IDLE;
                    start_mux_q <= bus.continuous;
                    tmo_q <= '0;
                end
                ERR: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.start_mux   = start_mux_q;
    assign bus.start_dac   = start_dac_q;
    assign bus.start_adc   = start_adc_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.fsm_done    = fsm_done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.fsm_busy    = state_q != IDLE;
    assign bus.inj_p       = inj_p_q;
    assign bus.inj_n       = wrap_inc(inj_p_q);
    assign bus.meas_p      = meas_p_q;
    assign bus.meas_n      = wrap_inc(meas_p_q);
    assign bus.sample_idx  = smp_q;
endmodule

// File: tb/tb_eit_scan_sequencer.sv
// tb_eit_scan_sequencer: scoreboard bench for two sequencer instances (skip and no-skip) on 4 electrodes
module tb_eit_scan_sequencer;
    localparam int N = 4;
    localparam int S = 2;
    localparam int S_BUSY = 0, S_TERR = 1, S_EL = 2, S_SMP = 3, S_ADC = 4, S_DONE = 5;
    localparam int S_MV = 6, S_PULSE = 7, S_DAC = 8, S_FDONE = 9, S_FLAG = 10;

    typedef struct {
        string       nm;
        int          k;
        int          sel;
        logic [31:0] exp;
        logic [31:0] aux;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_dac, spur;
    logic       sm_d, sd_d;
    int         n_checks = 0;
    int         n_fail = 0;
    int         adc_cnt[2] = '{0, 0};
    int         done_cnt[2] = '{0, 0};
    int         mv_cnt[2] = '{0, 0};
    snap_t      snap_q[$];
    logic [9:0] exp0[$];
    logic [9:0] exp1[$];

    eit_scan_sequencer_if #(.N_ELEC(N), .SAMPLES(S)) bus0 ();
    eit_scan_sequencer_if #(.N_ELEC(N), .SAMPLES(S)) bus1 ();

    eit_scan_sequencer #(.N_ELEC(N), .SAMPLES(S), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16), .SKIP_INJ(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    eit_scan_sequencer #(.N_ELEC(N), .SAMPLES(S), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16), .SKIP_INJ(0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input int k, input int sel);
        logic [31:0] r;
        r = '0;
        case (sel)
            S_BUSY:  r = 32'(k != 0 ? bus1.fsm_busy : bus0.fsm_busy);
            S_TERR:  r = 32'(k != 0 ? bus1.timeout_err : bus0.timeout_err);
            S_EL:    r = 32'(k != 0 ? {bus1.inj_p, bus1.inj_n, bus1.meas_p, bus1.meas_n}
                                    : {bus0.inj_p, bus0.inj_n, bus0.meas_p, bus0.meas_n});
            S_SMP:   r = 32'(k != 0 ? bus1.sample_idx : bus0.sample_idx);
            S_ADC:   r = 32'(adc_cnt[k]);
            S_DONE:  r = 32'(done_cnt[k]);
            S_MV:    r = 32'(mv_cnt[k]);
            S_PULSE: r = 32'(k != 0 ? {bus1.start_mux, bus1.start_dac, bus1.start_adc, bus1.meas_valid, bus1.fsm_done}
                                    : {bus0.start_mux, bus0.start_dac, bus0.start_adc, bus0.meas_valid, bus0.fsm_done});
            S_DAC:   r = 32'(k != 0 ? bus1.start_dac : bus0.start_dac);
            S_FDONE: r = 32'(k != 0 ? bus1.fsm_done : bus0.fsm_done);
            default: r = '0;
        endcase
        return r;
    endfunction

    // expected {inj_p, inj_n, meas_p, meas_n, sample_idx} at a meas_valid pulse
    function automatic logic [9:0] mk(input int i, input int m);
        return {2'(i), 2'((i + 1) % N), 2'(m), 2'((m + 1) % N), 2'(S)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int k, input int sel, input logic [31:0] e);
        snap_q.push_back('{nm, k, sel, e, 32'd0});
    endtask

    task automatic flag(input string nm, input logic ok);
        snap_q.push_back('{nm, 0, S_FLAG, 32'd1, 32'(ok)});
    endtask

    task automatic wait_for(input string nm, input int k, input int sel, input logic [31:0] v, input int lim);
        for (int i = 0; i < lim && obs(k, sel) != v; i++) tick();
        flag(nm, obs(k, sel) == v);
    endtask

    task automatic pulse_start(input int k);
        if (k != 0) bus1.start = 1'b1;
        else bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    // driver-side responder: acknowledges each start pulse; spur mode adds ignored early readies and a late dac_ready
    initial begin
        sm_d = 1'b0;
        sd_d = 1'b0;
        bus0.step_done = 1'b0; bus0.dac_ready = 1'b0; bus0.adc_ready = 1'b0;
        bus1.step_done = 1'b0; bus1.dac_ready = 1'b0; bus1.adc_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus0.step_done = bus0.start_mux || (spur && sm_d);
            bus0.dac_ready = en_dac && (spur ? sd_d : bus0.start_dac);
            bus0.adc_ready = bus0.start_adc || (spur && bus0.start_dac);
            bus1.step_done = bus1.start_mux;
            bus1.dac_ready = bus1.start_dac;
            bus1.adc_ready = bus1.start_adc;
            sm_d = bus0.start_mux;
            sd_d = bus0.start_dac;
        end
    end

    // monitor: counts pulses, scores meas_valid against the expected queues, then evaluates pending snapshots
    initial begin
        logic [31:0] p, el, sm, v;
        logic [9:0]  got, want;
        logic        have;
        snap_t       s;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                p = obs(k, S_PULSE);
                if (p[2] === 1'b1) adc_cnt[k]++;
                if (p[0] === 1'b1) done_cnt[k]++;
                if (p[1] === 1'b1) begin
                    el = obs(k, S_EL);
                    sm = obs(k, S_SMP);
                    got = {el[7:0], sm[1:0]};
                    mv_cnt[k]++;
                    n_checks++;
                    have = (k == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
                    if (!have) begin
                        n_fail++;
                        $display("FAIL meas_valid dut%0d unexpected: got %h, none expected", k, got);
                    end else begin
                        if (k == 0) want = exp0.pop_front();
                        else want = exp1.pop_front();
                        if (got !== want) begin
                            n_fail++;
                            $display("FAIL meas_valid dut%0d: got %h expected %h", k, got, want);
                        end
                    end
                end
            end
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                v = (s.sel == S_FLAG) ? s.aux : obs(s.k, s.sel);
                n_checks++;
                if (v !== s.exp) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: got %0h expected %0h", s.nm, s.k, v, s.exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        en_dac = 1'b1;
        spur = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.continuous = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.continuous = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", 0, S_BUSY, 0);
        chk("rst_terr", 0, S_TERR, 0);
        chk("rst_elec", 0, S_EL, 32'h11);
        chk("rst_smp", 0, S_SMP, 0);
        chk("rst_pulses", 0, S_PULSE, 0);
        chk("rst_elec", 1, S_EL, 32'h11);
        tick();
        // full frame with skip
        exp0.push_back(mk(0, 2)); exp0.push_back(mk(1, 3)); exp0.push_back(mk(2, 0)); exp0.push_back(mk(3, 1));
        pulse_start(0);
        wait_for("wait_done_f1", 0, S_FDONE, 1, 400);
        chk("f1_mv_cnt", 0, S_MV, 4);
        chk("f1_adc_cnt", 0, S_ADC, 8);
        chk("f1_done_cnt", 0, S_DONE, 1);
        tick();
        chk("f1_idle", 0, S_BUSY, 0);
        // full frame without skip
        for (int i = 0; i < N; i++)
            for (int m = 0; m < N; m++) exp1.push_back(mk(i, m));
        pulse_start(1);
        wait_for("wait_done_noskip", 1, S_FDONE, 1, 400);
        chk("ns_mv_cnt", 1, S_MV, 16);
        chk("ns_adc_cnt", 1, S_ADC, 32);
        chk("ns_done_cnt", 1, S_DONE, 1);
        tick();
        chk("ns_idle", 1, S_BUSY, 0);
        // spurious readies in SETTLE and DAC are ignored
        spur = 1'b1;
        exp0.push_back(mk(0, 2)); exp0.push_back(mk(1, 3)); exp0.push_back(mk(2, 0)); exp0.push_back(mk(3, 1));
        pulse_start(0);
        wait_for("wait_done_spur", 0, S_FDONE, 1, 400);
        chk("spur_mv_cnt", 0, S_MV, 8);
        chk("spur_adc_cnt", 0, S_ADC, 16);
        chk("spur_done_cnt", 0, S_DONE, 2);
        tick();
        spur = 1'b0;
        // DAC timeout
        en_dac = 1'b0;
        pulse_start(0);
        wait_for("wait_dac_entry", 0, S_DAC, 1, 100);
        repeat (15) tick();
        chk("tmo_not_yet", 0, S_TERR, 0);
        chk("tmo_busy_wait", 0, S_BUSY, 1);
        tick();
        chk("tmo_set", 0, S_TERR, 1);
        chk("tmo_err_busy", 0, S_BUSY, 1);
        tick();
        chk("tmo_idle", 0, S_BUSY, 0);
        chk("tmo_sticky", 0, S_TERR, 1);
        chk("tmo_no_done", 0, S_DONE, 2);
        en_dac = 1'b1;
        pulse_start(0);
        chk("start_clears_terr", 0, S_TERR, 0);
        chk("restart_busy", 0, S_BUSY, 1);
        // abort during the second ADC sample
        wait_for("wait_second_sample", 0, S_SMP, 1, 100);
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk("abort_busy", 0, S_BUSY, 0);
        chk("abort_elec", 0, S_EL, 32'h11);
        chk("abort_smp", 0, S_SMP, 0);
        chk("abort_pulses", 0, S_PULSE, 0);
        chk("abort_terr", 0, S_TERR, 0);
        repeat (20) tick();
        chk("abort_mv_cnt", 0, S_MV, 8);
        chk("abort_adc_cnt", 0, S_ADC, 18);
        chk("abort_done_cnt", 0, S_DONE, 2);
        // continuous mode with a mid-frame start that must be ignored
        bus0.continuous = 1'b1;
        exp0.push_back(mk(0, 2)); exp0.push_back(mk(1, 3)); exp0.push_back(mk(2, 0)); exp0.push_back(mk(3, 1));
        pulse_start(0);
        repeat (10) tick();
        pulse_start(0);
        wait_for("wait_done_c1", 0, S_FDONE, 1, 400);
        exp0.push_back(mk(0, 2)); exp0.push_back(mk(1, 3)); exp0.push_back(mk(2, 0)); exp0.push_back(mk(3, 1));
        chk("c1_done_cnt", 0, S_DONE, 3);
        chk("c1_mv_cnt", 0, S_MV, 12);
        tick();
        chk("c2_restart_pulse", 0, S_PULSE, 32'h10);
        chk("c2_restart_elec", 0, S_EL, 32'h1b);
        chk("c2_busy", 0, S_BUSY, 1);
        bus0.continuous = 1'b0;
        wait_for("wait_done_c2", 0, S_FDONE, 1, 400);
        chk("c2_done_cnt", 0, S_DONE, 4);
        chk("c2_mv_cnt", 0, S_MV, 16);
        chk("c2_adc_cnt", 0, S_ADC, 34);
        tick();
        chk("c2_idle", 0, S_BUSY, 0);
        flag("exp_queues_drained", exp0.size() == 0 && exp1.size() == 0);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eit_scan_sequencer.md
Name: eit_scan_sequencer

Overview:
Parametrised successor to the single-step slave sequencer. It autonomously walks a full adjacent-pattern EIT frame: for every injection pair it visits every measurement pair, and for each one sequences MUX, settle, DAC and N ADC samples. It adds timeouts, abort, sample repetition and continuous-frame mode. It sits between the top-level controller and the mux/DAC/ADC drivers.

Parameters:
N_ELEC, 16, number of electrodes (>=4); IDX_W = $clog2(N_ELEC) is localparam.
SAMPLES, 4, ADC conversions per measurement (>=1).
SETTLE_CYCLES, 8, idle cycles after step_done before the DAC start (0 allowed).
TIMEOUT_CYCLES, 1024, maximum wait for any ready/done input.
SKIP_INJ, 1, 1 = skip measurement pairs that touch an injection electrode.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a frame (accepted only in IDLE)
abort  in  1  synchronous abort, returns to IDLE
continuous  in  1  sampled at end of frame; 1 = start the next frame immediately
step_done  in  1  mux switching complete
dac_ready  in  1  DAC output stable
adc_ready  in  1  ADC conversion complete
start_mux  out  1  one-cycle pulse
start_dac  out  1  one-cycle pulse
start_adc  out  1  one-cycle pulse
inj_p, inj_n  out  IDX_W  current injection electrodes
meas_p, meas_n  out  IDX_W  current measurement electrodes
sample_idx  out  $clog2(SAMPLES+1)  ADC samples completed in the current measurement
meas_valid  out  1  one-cycle pulse after the last sample of a measurement
fsm_busy  out  1  high in every state except IDLE
fsm_done  out  1  one-cycle pulse at frame completion
timeout_err  out  1  sticky; cleared by the next accepted start or by rst

Behaviour:
- Reset: state=IDLE. All pulses 0. inj_p=0, inj_n=1, meas_p=0, meas_n=1. sample_idx=0, fsm_busy=0, timeout_err=0.
- Pairs are always adjacent: inj_n=(inj_p+1) mod N_ELEC and meas_n=(meas_p+1) mod N_ELEC. Wrap N_ELEC-1 -> 0 explicitly, not by width overflow.
- Skip rule (SKIP_INJ=1): a measurement pair is skipped if meas_p or meas_n equals inj_p or inj_n. This gives N_ELEC-3 measurements per injection. SKIP_INJ=0 gives N_ELEC. Skipped pairs consume no cycles in MUX or later states; the next valid pair is computed in NEXT.
- States: IDLE, MUX, SETTLE, DAC, ADC, NEXT, DONE, ERR.
- IDLE: when start=1, clear timeout_err, load inj_p=0 and the first valid meas_p, go to MUX. start_mux pulses in the first cycle of MUX.
- MUX: wait for step_done, then go to SETTLE. If SETTLE_CYCLES=0, go directly to DAC.
- SETTLE: count SETTLE_CYCLES cycles, then go to DAC.
- DAC: start_dac pulses in the first cycle; wait for dac_ready, then go to ADC.
- ADC: start_adc pulses on entry and again after each adc_ready while sample_idx<SAMPLES; sample_idx increments on each adc_ready. After the SAMPLES-th adc_ready, pulse meas_valid (electrode outputs still show that measurement) and go to NEXT.
- NEXT (1 cycle): advance meas_p to the next valid pair. If the measurement pairs are exhausted, advance inj_p and reset meas_p to the first valid pair. If inj_p wraps past N_ELEC-1, go to DONE; otherwise go to MUX with sample_idx=0.
- DONE (1 cycle): pulse fsm_done. If continuous=1, reload as from IDLE and go to MUX; otherwise go to IDLE.
- Timeout: a counter clears on entry to MUX, DAC and ADC and on each adc_ready. If it reaches TIMEOUT_CYCLES without the awaited input, set timeout_err and go to ERR. ERR lasts 1 cycle, then goes to IDLE; no fsm_done.
- abort=1 in any state: go to IDLE next cycle with no pulses and no fsm_done; the electrode outputs return to their reset values. abort has priority over start and over every ready input in the same cycle.
- start while busy is ignored. step_done, dac_ready and adc_ready outside their wait state are ignored and are not latched.
- A ready input arriving in the same cycle the timeout expires is accepted (ready wins).
- rst mid-frame returns everything to its reset values next edge.

Test Plan:
- N_ELEC=4, SAMPLES=2, SETTLE_CYCLES=2, SKIP_INJ=1; start plus prompt ready responses -> 4 meas_valid pulses with (inj,meas) = (0-1,2-3), (1-2,3-0), (2-3,0-1), (3-0,1-2); then one fsm_done; 8 start_adc pulses in total.
- Same configuration, SKIP_INJ=0 -> 16 meas_valid pulses, then fsm_done; meas_p sequence 0,1,2,3 per injection.
- Withhold dac_ready with TIMEOUT_CYCLES=16 -> timeout_err=1 exactly 16 cycles after DAC entry, ERR then IDLE, no fsm_done; the next start clears timeout_err.
- Assert abort during the second ADC sample -> IDLE next cycle, fsm_busy=0, inj_p=0, meas_p=0, no meas_valid.
- continuous=1 across frame end -> fsm_done pulse followed by start_mux 1 cycle later with inj_p=0; start asserted mid-frame has no effect.
- adc_ready pulsed in the same cycle as start_dac, and step_done in SETTLE -> both ignored; the sequence still waits for the correct ready.
